fft_frame_wr_sequencer: RTL and testbench

//  Sequences the FFT input-buffer address counter (sclr_cnt/en_cnt/tc_cnt/addr) to capture

---
 rtl/fft_frame_wr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fft_frame_wr_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_wr_sequencer.sv
// ============================================================================
// Module: fft_frame_wr_sequencer
//
// Purpose
//   Drives an external FFT input-buffer address counter so that fixed-length
//   frames of 2**ADDR_W samples are captured into a two-bank ping-pong RAM.
//   A completed bank is offered to the FFT read side through frame_ready /
//   frame_bank. The reader returns it with a single-cycle frame_ack. While
//   both banks hold frames that have not been consumed, incoming samples are
//   discarded and each discarded sample is flagged on drop.
//
// Configuration macro
//   DROP_CNT_EN  : when defined, drop_cnt is a saturating count of discarded
//                  samples that clears only on reset. When undefined, no
//                  counter register exists and drop_cnt is tied to zero. The
//                  drop pulse is present in both builds.
//
// Parameters
//   ADDR_W       : address counter width; frame length is 2**ADDR_W samples
//   DROP_W       : width of drop_cnt
//
// Ports
//   clock        in   1         system clock, rising edge
//   reset        in   1         synchronous, active-high reset
//   enable       in   1         capture is armed while high
//   s_valid      in   1         input sample valid this cycle
//   tc_cnt       in   1         address counter terminal count (addr all ones)
//   addr         in   ADDR_W    address counter value, used as write address
//   sclr_cnt     out  1         synchronous clear to the address counter
//   en_cnt       out  1         count enable to the address counter
//   ram_we       out  1         RAM write enable (same as en_cnt)
//   ram_addr     out  ADDR_W+1  {ram_bank, addr}
//   ram_bank     out  1         bank currently being written
//   frame_ready  out  1         at least one bank holds an unacked frame
//   frame_bank   out  1         oldest full bank, valid while frame_ready
//   frame_ack    in   1         one-cycle pulse: reader finished frame_bank
//   busy         out  1         sequencer is not idle
//   drop         out  1         one-cycle pulse: sample discarded while stalled
//   drop_cnt     out  DROP_W    saturating count of discarded samples
// ============================================================================
module fft_frame_wr_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              s_valid,
    input  logic              tc_cnt,
    input  logic [ADDR_W-1:0] addr,
    output logic              sclr_cnt,
    output logic              en_cnt,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_bank,
    output logic              frame_ready,
    output logic              frame_bank,
    input  logic              frame_ack,
    output logic              busy,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_full;
    logic       r_wb;
    logic       r_rb;

    logic       w_isIdle;
    logic       w_isFill;
    logic       w_isStall;
    logic       w_write;
    logic       w_lastWrite;
    logic       w_ackFire;
    logic [1:0] w_ackClear;
    logic [1:0] w_fullAfterAck;
    logic [1:0] w_lastSet;
    logic [1:0] w_fullNext;
    logic       w_anyFree;
    logic       w_freeBank;
    logic       w_otherBank;
    logic       w_otherFree;
    logic       w_drop;

    // ------------------------------------------------------------------------
    // State decode. All outputs are combinational functions of registered
    // state plus the current inputs, so a valid sample is written in the
    // same cycle it arrives.
    // ------------------------------------------------------------------------
    assign w_isIdle  = (r_state == ST_IDLE);
    assign w_isFill  = (r_state == ST_FILL);
    assign w_isStall = (r_state == ST_STALL);

    assign w_write     = w_isFill & s_valid & enable;
    assign w_lastWrite = w_write & tc_cnt;
    assign w_drop      = w_isStall & s_valid;

    // An ack only counts when the bank it refers to is actually full; a
    // stray ack with nothing ready is ignored.
    assign w_ackFire  = frame_ack & r_full[r_rb];
    assign w_ackClear = w_ackFire ? (2'b01 << r_rb) : 2'b00;

    // Bank occupancy once this cycle's ack is taken into account. Decisions
    // about where to write next use this view, so a bank freed in the same
    // cycle as a last write is immediately reusable.
    assign w_fullAfterAck = r_full & ~w_ackClear;
    assign w_lastSet      = w_lastWrite ? (2'b01 << r_wb) : 2'b00;
    assign w_fullNext     = w_fullAfterAck | w_lastSet;

    assign w_anyFree   = ~(&w_fullAfterAck);
    assign w_freeBank  = w_fullAfterAck[r_wb] ? ~r_wb : r_wb;
    assign w_otherBank = ~r_wb;
    assign w_otherFree = ~w_fullAfterAck[w_otherBank];

    // ------------------------------------------------------------------------
    // Output mapping.
    // ------------------------------------------------------------------------
    assign sclr_cnt    = w_isIdle;
    assign en_cnt      = w_write;
    assign ram_we      = w_write;
    assign ram_bank    = r_wb;
    assign ram_addr    = {r_wb, addr};
    assign frame_ready = |r_full;
    assign frame_bank  = r_rb;
    assign busy        = ~w_isIdle;
    assign drop        = w_drop;

    // ------------------------------------------------------------------------
    // Main sequencer. Bank flags and the read pointer update every cycle from
    // the ack/last-write logic above; the state machine chooses between
    // filling, stalling on two full banks, and idling with the counter held
    // clear. The address counter wraps to zero on its own after the last
    // write, so no explicit clear is needed when moving to the next bank.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_full  <= 2'b00;
            r_wb    <= 1'b0;
            r_rb    <= 1'b0;
        end else begin
            r_full <= w_fullNext;
            if (w_ackFire) begin
                r_rb <= ~r_rb;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        if (w_anyFree) begin
                            r_state <= ST_FILL;
                            r_wb    <= w_freeBank;
                        end else begin
                            r_state <= ST_STALL;
                        end
                    end
                end

                ST_FILL: begin
                    // A last write can only happen with enable high, so it
                    // takes priority; a partial frame abandoned by enable
                    // going low leaves its bank flag clear.
                    if (w_lastWrite) begin
                        if (w_otherFree) begin
                            r_wb <= w_otherBank;
                        end else begin
                            r_state <= ST_STALL;
                        end
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_STALL: begin
                    // The sample arriving in the freeing cycle is still
                    // dropped; writing resumes on the following cycle at the
                    // counter's current value, which is zero after the wrap.
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_anyFree) begin
                        r_state <= ST_FILL;
                        r_wb    <= w_freeBank;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DROP_CNT_EN
    logic [DROP_W-1:0] r_dropCnt;

    // ------------------------------------------------------------------------
    // Saturating drop counter; it holds at all ones rather than wrapping so
    // that a large overflow is never mistaken for a small count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dropCnt <= '0;
        end else if (w_drop && (r_dropCnt != {DROP_W{1'b1}})) begin
            r_dropCnt <= r_dropCnt + DROP_W'(1);
        end
    end

    assign drop_cnt = r_dropCnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_frame_wr_sequencer.sv
// ============================================================================
// Testbench: tb_fft_frame_wr_sequencer
//
// Drives fft_frame_wr_sequencer together with a behavioural model of the
// external address counter. Each sample the bench sends is paired with the
// outcome it should produce (a write to {bank, addr} or a drop), pushed to a
// queue; a negedge monitor pops that queue every time the DUT writes or
// drops. Status outputs are checked at quiet points between sample runs.
// ============================================================================
module tb_fft_frame_wr_sequencer;

    localparam int ADDR_W   = 10;
    localparam int DROP_W   = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              s_valid;
    logic              tc_cnt;
    logic [ADDR_W-1:0] addr = '0;
    logic              sclr_cnt;
    logic              en_cnt;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic              ram_bank;
    logic              frame_ready;
    logic              frame_bank;
    logic              frame_ack;
    logic              busy;
    logic              drop;
    logic [DROP_W-1:0] drop_cnt;

    logic [ADDR_W+1:0] expQ[$];
    logic [ADDR_W+1:0] monObs;
    logic [ADDR_W+1:0] monExp;
    int                assertCount = 0;
    int                failCount   = 0;
    int                dropsSeen   = 0;

    fft_frame_wr_sequencer #(
        .ADDR_W (ADDR_W),
        .DROP_W (DROP_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .s_valid     (s_valid),
        .tc_cnt      (tc_cnt),
        .addr        (addr),
        .sclr_cnt    (sclr_cnt),
        .en_cnt      (en_cnt),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_bank    (ram_bank),
        .frame_ready (frame_ready),
        .frame_bank  (frame_bank),
        .frame_ack   (frame_ack),
        .busy        (busy),
        .drop        (drop),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock = ~clock;

    // External address counter: clear wins over count, wraps naturally.
    always @(posedge clock) begin
        if (sclr_cnt === 1'b1) begin
            addr <= '0;
        end else if (en_cnt === 1'b1) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    assign tc_cnt = (addr == {ADDR_W{1'b1}});

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] expDropCnt();
`ifdef DROP_CNT_EN
        return (dropsSeen > DROP_MAX) ? 32'(DROP_MAX) : 32'(dropsSeen);
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard monitor: every write or drop must match the oldest entry.
    always @(negedge clock) begin
        if (reset === 1'b0 && (ram_we === 1'b1 || drop === 1'b1)) begin
            monObs = (drop === 1'b1) ? {1'b1, {(ADDR_W+1){1'b0}}} : {1'b0, ram_addr};
            checkOutput("en_cnt_eq_ram_we", en_cnt, ram_we);
            checkOutput("output_needs_valid", s_valid, 1'b1);
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_output", expQ.size(), 1);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sb_write_or_drop", monObs, monExp);
            end
        end
    end

    task automatic applyStimulus(input logic valid, input logic ack);
        s_valid   = valid;
        frame_ack = ack;
        @(posedge clock);
        #1;
    endtask

    task automatic holdAndSample();
        s_valid   = 1'b0;
        frame_ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic writeRun(input logic bank, input int start, input int count,
                            input int gap, input logic ackOnLast);
        for (int i = 0; i < count; i++) begin
            expQ.push_back({1'b0, bank, ADDR_W'(start + i)});
            applyStimulus(1'b1, ackOnLast && (i == count - 1));
            repeat (gap) applyStimulus(1'b0, 1'b0);
        end
    endtask

    task automatic dropRun(input int count, input logic ackOnLast);
        for (int i = 0; i < count; i++) begin
            expQ.push_back({1'b1, {(ADDR_W+1){1'b0}}});
            dropsSeen++;
            applyStimulus(1'b1, ackOnLast && (i == count - 1));
        end
    endtask

    task automatic doReset();
        reset     = 1'b1;
        enable    = 1'b0;
        s_valid   = 1'b0;
        frame_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        expQ.delete();
        dropsSeen = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        // Reset state
        holdAndSample();
        checkOutput("rst_sclr_cnt", sclr_cnt, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_frame_ready", frame_ready, 1'b0);
        checkOutput("rst_frame_bank", frame_bank, 1'b0);
        checkOutput("rst_ram_bank", ram_bank, 1'b0);
        checkOutput("rst_ram_we", ram_we, 1'b0);
        checkOutput("rst_drop", drop, 1'b0);
        checkOutput("rst_drop_cnt", drop_cnt, 32'd0);
        nextCycle();

        // Back-to-back frame into bank 0
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0);
        writeRun(1'b0, 0, 1024, 0, 1'b0);
        holdAndSample();
        checkOutput("t1_frame_ready", frame_ready, 1'b1);
        checkOutput("t1_frame_bank", frame_bank, 1'b0);
        checkOutput("t1_ram_bank", ram_bank, 1'b1);
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_sb_drained", expQ.size(), 0);
        nextCycle();

        applyStimulus(1'b0, 1'b1);
        holdAndSample();
        checkOutput("ack0_frame_ready", frame_ready, 1'b0);
        checkOutput("ack0_frame_bank", frame_bank, 1'b1);
        nextCycle();

        // One-in-three duty into bank 1: not complete after 1023 valids
        writeRun(1'b1, 0, 1023, 2, 1'b0);
        holdAndSample();
        checkOutput("t2_not_done_ready", frame_ready, 1'b0);
        checkOutput("t2_not_done_bank", ram_bank, 1'b1);
        nextCycle();
        writeRun(1'b1, 1023, 1, 2, 1'b0);
        holdAndSample();
        checkOutput("t2_frame_ready", frame_ready, 1'b1);
        checkOutput("t2_frame_bank", frame_bank, 1'b1);
        checkOutput("t2_ram_bank", ram_bank, 1'b0);
        nextCycle();

        applyStimulus(1'b0, 1'b1);
        holdAndSample();
        checkOutput("ack1_frame_ready", frame_ready, 1'b0);
        checkOutput("ack1_frame_bank", frame_bank, 1'b0);
        nextCycle();

        // Abort a partial frame at addr 500; a valid with enable low is ignored
        writeRun(1'b0, 0, 500, 0, 1'b0);
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0);
        holdAndSample();
        checkOutput("t4_sclr_cnt", sclr_cnt, 1'b1);
        checkOutput("t4_busy", busy, 1'b0);
        checkOutput("t4_frame_ready", frame_ready, 1'b0);
        nextCycle();
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Two frames with no ack, then five drops while stalled
        writeRun(1'b0, 0, 1024, 0, 1'b0);
        writeRun(1'b1, 0, 1024, 0, 1'b0);
        holdAndSample();
        checkOutput("t3_stall_busy", busy, 1'b1);
        checkOutput("t3_stall_ready", frame_ready, 1'b1);
        checkOutput("t3_stall_frame_bank", frame_bank, 1'b0);
        nextCycle();
        dropRun(5, 1'b0);
        holdAndSample();
        checkOutput("t3_drop_cnt5", drop_cnt, expDropCnt());
        checkOutput("t3_still_busy", busy, 1'b1);
        nextCycle();
        // Ack frees bank 0; the valid in the freeing cycle is still dropped
        dropRun(1, 1'b1);
        holdAndSample();
        checkOutput("t3_ack_frame_bank", frame_bank, 1'b1);
        checkOutput("t3_ack_ram_bank", ram_bank, 1'b0);
        checkOutput("t3_ack_ready", frame_ready, 1'b1);
        nextCycle();
        writeRun(1'b0, 0, 10, 0, 1'b0);

        // Last writes coinciding with acks of the other bank: no stall
        writeRun(1'b0, 10, 1014, 0, 1'b1);
        writeRun(1'b1, 0, 1024, 0, 1'b1);
        writeRun(1'b0, 0, 1, 0, 1'b0);
        holdAndSample();
        checkOutput("t5_frame_ready", frame_ready, 1'b1);
        checkOutput("t5_frame_bank", frame_bank, 1'b1);
        checkOutput("t5_ram_bank", ram_bank, 1'b0);
        checkOutput("t5_busy", busy, 1'b1);
        nextCycle();

        // Fill to a stall again and push the drop counter past saturation
        writeRun(1'b0, 1, 1023, 0, 1'b0);
        dropRun(14, 1'b0);
        holdAndSample();
        checkOutput("t6_drop_cnt_sat", drop_cnt, expDropCnt());
        nextCycle();

        // Enable low while stalled keeps completed frames
        enable = 1'b0;
        applyStimulus(1'b0, 1'b0);
        holdAndSample();
        checkOutput("idle_keep_busy", busy, 1'b0);
        checkOutput("idle_keep_sclr", sclr_cnt, 1'b1);
        checkOutput("idle_keep_ready", frame_ready, 1'b1);
        checkOutput("idle_keep_bank", frame_bank, 1'b1);
        nextCycle();
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0);
        dropRun(1, 1'b0);
        holdAndSample();
        checkOutput("restall_busy", busy, 1'b1);
        checkOutput("restall_drop_cnt", drop_cnt, expDropCnt());
        nextCycle();

        // Reset with both banks full discards everything
        doReset();
        holdAndSample();
        checkOutput("midrst_ready", frame_ready, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_frame_bank", frame_bank, 1'b0);
        checkOutput("midrst_drop_cnt", drop_cnt, 32'd0);
        nextCycle();

        // An ack with nothing ready is ignored
        applyStimulus(1'b0, 1'b1);
        holdAndSample();
        checkOutput("stray_ack_bank", frame_bank, 1'b0);
        checkOutput("stray_ack_ready", frame_ready, 1'b0);
        nextCycle();
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0);
        writeRun(1'b0, 0, 4, 0, 1'b0);
        holdAndSample();
        checkOutput("final_sb_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
